// File: rtl/c64_bus_pkg.sv
// Shared definitions for the C64 bus ownership logic (arbiter and VIC-II model).
package c64_bus_pkg;

  // Who currently owns, or is about to own, the phi2 half of the bus
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    GRANT_VIC = 2'd2,
    GRANT_EXT = 2'd3
  } arb_state_t;

  // The 6510 can issue at most three back-to-back writes before halting on RDY
  localparam int C64_BA_DELAY = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used to count stolen bus cycles.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Clear beats increment; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/c64_bus_arbiter.sv
// Owner side of the 6510 RDY/AEC handshake: hands the phi2 bus to VIC-II or
// expansion DMA, holding AEC high for BA_DELAY cycles after RDY drops so the
// CPU can finish any pending writes.
module c64_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int BA_DELAY = C64_BA_DELAY,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cyc_stb,
  input  logic             vic_req,
  input  logic             ext_req,
  input  logic             cnt_clr,
  output logic             rdy,
  output logic             aec,
  output logic             vic_grant,
  output logic             ext_grant,
  output logic [CNT_W-1:0] steal_cnt
);

  // The first WAIT strobe already counts as one delay cycle, hence the -1
  localparam logic [2:0] DCNT_INIT = (BA_DELAY > 0) ? 3'(BA_DELAY - 1) : 3'd0;

  arb_state_t state, state_nxt;
  logic [2:0] dcnt, dcnt_nxt;
  logic       rdy_nxt, aec_nxt, vic_grant_nxt, ext_grant_nxt;
  logic       steal_inc;

  // State, delay counter and registered handshake outputs advance only on bus-cycle strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dcnt      <= 3'd0;
      rdy       <= 1'b1;
      aec       <= 1'b1;
      vic_grant <= 1'b0;
      ext_grant <= 1'b0;
    end else if (cyc_stb) begin
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      rdy       <= rdy_nxt;
      aec       <= aec_nxt;
      vic_grant <= vic_grant_nxt;
      ext_grant <= ext_grant_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless a transition says otherwise
  always_comb begin
    state_nxt     = state;
    dcnt_nxt      = dcnt;
    rdy_nxt       = rdy;
    aec_nxt       = aec;
    vic_grant_nxt = vic_grant;
    ext_grant_nxt = ext_grant;

    case (state)
      IDLE: begin
        if (vic_req || ext_req) begin
          rdy_nxt = 1'b0;
          if (BA_DELAY == 0) begin
            aec_nxt = 1'b0;
            if (vic_req) begin
              state_nxt     = GRANT_VIC;
              vic_grant_nxt = 1'b1;
            end else begin
              state_nxt     = GRANT_EXT;
              ext_grant_nxt = 1'b1;
            end
          end else begin
            state_nxt = WAIT;
            dcnt_nxt  = DCNT_INIT;
          end
        end
      end

      WAIT: begin
        if (!vic_req && !ext_req) begin
          state_nxt = IDLE;
          dcnt_nxt  = 3'd0;
          rdy_nxt   = 1'b1;
        end else if (dcnt != 3'd0) begin
          dcnt_nxt = dcnt - 3'd1;
        end else begin
          aec_nxt = 1'b0;
          if (vic_req) begin
            state_nxt     = GRANT_VIC;
            vic_grant_nxt = 1'b1;
          end else begin
            state_nxt     = GRANT_EXT;
            ext_grant_nxt = 1'b1;
          end
        end
      end

      GRANT_VIC: begin
        if (!vic_req) begin
          vic_grant_nxt = 1'b0;
          if (ext_req) begin
            state_nxt     = GRANT_EXT;
            ext_grant_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            rdy_nxt   = 1'b1;
            aec_nxt   = 1'b1;
          end
        end
      end

      GRANT_EXT: begin
        if (!ext_req) begin
          ext_grant_nxt = 1'b0;
          if (vic_req) begin
            state_nxt     = GRANT_VIC;
            vic_grant_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            rdy_nxt   = 1'b1;
            aec_nxt   = 1'b1;
          end
        end
      end

      default: begin
        state_nxt     = IDLE;
        dcnt_nxt      = 3'd0;
        rdy_nxt       = 1'b1;
        aec_nxt       = 1'b1;
        vic_grant_nxt = 1'b0;
        ext_grant_nxt = 1'b0;
      end
    endcase
  end

  // A cycle is stolen whenever the bus is already granted at the strobe
  always_comb begin
    steal_inc = cyc_stb && ((state == GRANT_VIC) || (state == GRANT_EXT));
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_steal_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (steal_inc),
    .clr  (cnt_clr),
    .count(steal_cnt)
  );

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Bench for c64_bus_arbiter: three instances (BA_DELAY=3/16-bit, BA_DELAY=0/16-bit,
// BA_DELAY=3/4-bit) share one directed stimulus and are checked against a
// strobe-counting reference model every cycle, plus pinned literal expectations.
module tb_c64_bus_arbiter;

  logic clk = 1'b0;
  logic reset, cyc_stb, vic_req, ext_req, cnt_clr;
  logic rdy_w[3], aec_w[3], vg_w[3], eg_w[3];
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int  checks = 0;
  int  errors = 0;
  int  sn = 0;
  bit  check_en = 1'b0;

  // Reference model state: 0=no owner, 1=VIC, 2=expansion
  int  m_owner[3];
  int  m_halted[3];
  int  m_start[3];
  int  m_cnt[3];
  int  m_strobe = 0;

  always #5 clk = ~clk;

  c64_bus_arbiter #(.BA_DELAY(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .cyc_stb(cyc_stb), .vic_req(vic_req), .ext_req(ext_req),
    .cnt_clr(cnt_clr), .rdy(rdy_w[0]), .aec(aec_w[0]), .vic_grant(vg_w[0]),
    .ext_grant(eg_w[0]), .steal_cnt(cnt_a)
  );

  c64_bus_arbiter #(.BA_DELAY(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .cyc_stb(cyc_stb), .vic_req(vic_req), .ext_req(ext_req),
    .cnt_clr(cnt_clr), .rdy(rdy_w[1]), .aec(aec_w[1]), .vic_grant(vg_w[1]),
    .ext_grant(eg_w[1]), .steal_cnt(cnt_b)
  );

  c64_bus_arbiter #(.BA_DELAY(3), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .cyc_stb(cyc_stb), .vic_req(vic_req), .ext_req(ext_req),
    .cnt_clr(cnt_clr), .rdy(rdy_w[2]), .aec(aec_w[2]), .vic_grant(vg_w[2]),
    .ext_grant(eg_w[2]), .steal_cnt(cnt_c)
  );

  function automatic int ba_of(input int m);
    return (m == 1) ? 0 : 3;
  endfunction

  function automatic int cnt_max_of(input int m);
    return (m == 2) ? 15 : 65535;
  endfunction

  function automatic int dut_cnt(input int m);
    if (m == 0) return int'(cnt_a);
    if (m == 1) return int'(cnt_b);
    return int'(cnt_c);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit stb, input bit v, input bit e, input bit clr, input bit rst);
    cyc_stb = stb;
    vic_req = v;
    ext_req = e;
    cnt_clr = clr;
    reset   = rst;
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: a strobe edge, then a gap edge with inverted requests that must be ignored
  task automatic strobe(input bit v, input bit e, input bit clr);
    applyStimulus(1'b1, v, e, clr, 1'b0);
    sn++;
    applyStimulus(1'b0, !v, !e, 1'b0, 1'b0);
  endtask

  // Reference model: timing is expressed as "strobes since RDY fell" rather than a down-counter
  always @(posedge clk) begin : model_p
    int n, nxt_owner, nxt_halted, nxt_start, nxt_cnt;
    bit own_req, oth_req;
    n = m_strobe + 1;
    if (cyc_stb) m_strobe <= n;
    for (int m = 0; m < 3; m++) begin
      nxt_owner  = m_owner[m];
      nxt_halted = m_halted[m];
      nxt_start  = m_start[m];
      nxt_cnt    = m_cnt[m];
      if (reset) begin
        nxt_owner  = 0;
        nxt_halted = 0;
        nxt_start  = 0;
        nxt_cnt    = 0;
      end else begin
        if (cyc_stb) begin
          if (m_halted[m] == 0) begin
            if (vic_req || ext_req) begin
              nxt_halted = 1;
              nxt_start  = n;
              if (ba_of(m) == 0) nxt_owner = vic_req ? 1 : 2;
            end
          end else if (m_owner[m] == 0) begin
            if (!vic_req && !ext_req) nxt_halted = 0;
            else if (n - m_start[m] == ba_of(m)) nxt_owner = vic_req ? 1 : 2;
          end else begin
            own_req = (m_owner[m] == 1) ? vic_req : ext_req;
            oth_req = (m_owner[m] == 1) ? ext_req : vic_req;
            if (!own_req) begin
              if (oth_req) begin
                nxt_owner = 3 - m_owner[m];
              end else begin
                nxt_owner  = 0;
                nxt_halted = 0;
              end
            end
          end
        end
        if (cnt_clr) nxt_cnt = 0;
        else if (cyc_stb && m_owner[m] != 0 && m_cnt[m] < cnt_max_of(m)) nxt_cnt = m_cnt[m] + 1;
      end
      m_owner[m]  <= nxt_owner;
      m_halted[m] <= nxt_halted;
      m_start[m]  <= nxt_start;
      m_cnt[m]    <= nxt_cnt;
    end
  end

  // Compare every instance against the model on each falling edge
  always @(negedge clk) begin
    if (check_en) begin
      for (int m = 0; m < 3; m++) begin
        checkOutput($sformatf("m%0d.rdy", m), int'(rdy_w[m]), (m_halted[m] == 0) ? 1 : 0);
        checkOutput($sformatf("m%0d.aec", m), int'(aec_w[m]), (m_owner[m] == 0) ? 1 : 0);
        checkOutput($sformatf("m%0d.vic_grant", m), int'(vg_w[m]), (m_owner[m] == 1) ? 1 : 0);
        checkOutput($sformatf("m%0d.ext_grant", m), int'(eg_w[m]), (m_owner[m] == 2) ? 1 : 0);
        checkOutput($sformatf("m%0d.steal_cnt", m), dut_cnt(m), m_cnt[m]);
      end
    end
  end

  // Directed sequence with hand-computed expectations
  initial begin
    for (int m = 0; m < 3; m++) begin
      m_owner[m] = 0; m_halted[m] = 0; m_start[m] = 0; m_cnt[m] = 0;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_en = 1'b1;
    checkOutput("reset.rdy", int'(rdy_w[0]), 1);
    checkOutput("reset.aec", int'(aec_w[0]), 1);
    checkOutput("reset.vic_grant", int'(vg_w[0]), 0);
    checkOutput("reset.ext_grant", int'(eg_w[0]), 0);
    checkOutput("reset.steal_cnt", int'(cnt_a), 0);

    // VIC request with BA_DELAY=3 first seen at strobe 10
    for (int i = 1; i <= 9; i++) strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    checkOutput("s10.rdy", int'(rdy_w[0]), 0);
    checkOutput("s10.aec", int'(aec_w[0]), 1);
    checkOutput("s10.ba0_aec", int'(aec_w[1]), 0);
    checkOutput("s10.ba0_vic_grant", int'(vg_w[1]), 1);
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    checkOutput("s12.aec", int'(aec_w[0]), 1);
    strobe(1'b1, 1'b0, 1'b0);
    checkOutput("s13.aec", int'(aec_w[0]), 0);
    checkOutput("s13.vic_grant", int'(vg_w[0]), 1);
    for (int i = 14; i <= 19; i++) strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0);
    checkOutput("s20.rdy", int'(rdy_w[0]), 1);
    checkOutput("s20.aec", int'(aec_w[0]), 1);
    checkOutput("s20.vic_grant", int'(vg_w[0]), 0);
    checkOutput("s20.steal_cnt", int'(cnt_a), 7);
    checkOutput("s20.ba0_steal_cnt", int'(cnt_b), 10);

    // Abort during the delay window
    strobe(1'b1, 1'b0, 1'b0);
    checkOutput("abort.rdy_low", int'(rdy_w[0]), 0);
    checkOutput("abort.aec_high", int'(aec_w[0]), 1);
    strobe(1'b0, 1'b0, 1'b0);
    checkOutput("abort.rdy_back", int'(rdy_w[0]), 1);
    checkOutput("abort.aec", int'(aec_w[0]), 1);
    checkOutput("abort.steal_cnt", int'(cnt_a), 7);

    // BA_DELAY=0: expansion DMA granted on the very strobe it is seen
    strobe(1'b0, 1'b1, 1'b0);
    checkOutput("ba0.rdy", int'(rdy_w[1]), 0);
    checkOutput("ba0.aec", int'(aec_w[1]), 0);
    checkOutput("ba0.ext_grant", int'(eg_w[1]), 1);
    strobe(1'b0, 1'b0, 1'b0);
    checkOutput("ba0.release", int'(eg_w[1]), 0);

    // Simultaneous requests, VIC priority, handover without delay, no preemption
    strobe(1'b1, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0);
    checkOutput("prio.aec_wait", int'(aec_w[0]), 1);
    strobe(1'b1, 1'b1, 1'b0);
    checkOutput("prio.vic_grant", int'(vg_w[0]), 1);
    checkOutput("prio.ext_grant", int'(eg_w[0]), 0);
    strobe(1'b1, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    checkOutput("handover.ext_grant", int'(eg_w[0]), 1);
    checkOutput("handover.vic_grant", int'(vg_w[0]), 0);
    checkOutput("handover.aec", int'(aec_w[0]), 0);
    strobe(1'b1, 1'b1, 1'b0);
    checkOutput("nopreempt.ext_grant", int'(eg_w[0]), 1);
    checkOutput("nopreempt.vic_grant", int'(vg_w[0]), 0);
    strobe(1'b1, 1'b0, 1'b0);
    checkOutput("backtovic.vic_grant", int'(vg_w[0]), 1);
    strobe(1'b0, 1'b0, 1'b0);
    checkOutput("prio.idle_rdy", int'(rdy_w[0]), 1);
    checkOutput("prio.steal_cnt", int'(cnt_a), 13);

    // Clear without a strobe
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_nostb.steal_cnt", int'(cnt_a), 0);

    // Long grant: 4-bit counter saturates, then clear during a grant strobe
    for (int i = 0; i < 25; i++) strobe(1'b1, 1'b0, 1'b0);
    checkOutput("sat.cnt4", int'(cnt_c), 15);
    checkOutput("sat.cnt16", int'(cnt_a), 21);
    strobe(1'b1, 1'b0, 1'b1);
    checkOutput("clr.cnt4", int'(cnt_c), 0);
    checkOutput("clr.cnt16", int'(cnt_a), 0);
    checkOutput("clr.vic_grant", int'(vg_w[0]), 1);
    strobe(1'b1, 1'b0, 1'b0);
    checkOutput("after_clr.cnt16", int'(cnt_a), 1);

    // Reset in the middle of a grant, without and with a strobe
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst.rdy", int'(rdy_w[0]), 1);
    checkOutput("rst.aec", int'(aec_w[0]), 1);
    checkOutput("rst.vic_grant", int'(vg_w[0]), 0);
    checkOutput("rst.steal_cnt", int'(cnt_a), 0);
    strobe(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_stb.rdy", int'(rdy_w[0]), 1);
    checkOutput("rst_stb.aec", int'(aec_w[0]), 1);
    checkOutput("rst_stb.vic_grant", int'(vg_w[0]), 0);
    strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c64_bus_arbiter.md
Name: c64_bus_arbiter

Overview:
- Responder/owner side of the 6510 RDY/AEC handshake: decides who drives the system bus in the phi2 half-cycle.
- Requesters:
  - VIC-II DMA (badline character fetches, sprite fetches).
  - Expansion-port DMA.
- Drives the CPU's RDY (BA) and AEC inputs, enforcing the mandatory BA-to-AEC delay so the CPU can finish pending write cycles.
- Sits between the VIC-II model, the expansion port and the CPU wrapper; also counts stolen cycles for debug.

Parameters:
- BA_DELAY, 3, number of bus cycles between RDY falling and AEC falling (the 6510 performs at most 3 consecutive writes); legal range 0..7.
- CNT_W, 16, width of the stolen-cycle counter.

Ports:
- clk  input  1  system clock (single clock domain).
- reset  input  1  synchronous, active-high reset.
- cyc_stb  input  1  one-clk pulse per CPU bus cycle; all state changes occur only on clk edges with cyc_stb=1.
- vic_req  input  1  VIC-II requests the bus (level, held while DMA is needed).
- ext_req  input  1  expansion-port DMA request (level).
- cnt_clr  input  1  clears steal_cnt (takes effect on any clk edge).
- rdy  output  1  to CPU RDY; 0 = CPU must halt on its next read cycle.
- aec  output  1  to CPU AEC; 0 = CPU bus drivers tri-stated in phi2.
- vic_grant  output  1  VIC owns the bus this cycle.
- ext_grant  output  1  expansion DMA owns the bus this cycle.
- steal_cnt  output  CNT_W  saturating count of granted (stolen) cycles.

Behaviour:
- Reset: state IDLE; rdy=1, aec=1, vic_grant=0, ext_grant=0, steal_cnt=0, delay counter=0. Reset overrides cyc_stb and cnt_clr.
- Requests are sampled only on cyc_stb. Outputs are registered and change on the same edge as the state.
- States: IDLE, WAIT, GRANT_VIC, GRANT_EXT.
- IDLE:
  - If any request is seen on a strobe: rdy goes to 0 on that strobe's edge.
  - BA_DELAY>0: go to WAIT with dcnt=BA_DELAY-1.
  - BA_DELAY=0: go directly to GRANT (VIC priority), with rdy=0 and aec=0 together.
- WAIT (rdy=0, aec=1):
  - Both requests low on a strobe: back to IDLE, rdy=1. The delay is abandoned, not remembered.
  - Otherwise, if dcnt≠0: dcnt decrements.
  - Otherwise (dcnt=0): go to GRANT_VIC if vic_req, else GRANT_EXT. Set aec=0 and the matching grant.
  - Net timing: request first seen at strobe k → rdy=0 after k → aec=0 and grant=1 after strobe k+BA_DELAY.
- GRANT_x (rdy=0, aec=0, exactly one grant high):
  - Owner's request still high: stay. A VIC request arriving while in GRANT_EXT does not preempt.
  - Owner drops and the other requester is high: hand over on that strobe, with no BA delay (CPU already off the bus). rdy and aec stay 0; the grants swap in the same edge.
  - Owner drops and the other is low: go to IDLE; rdy=1, aec=1, grant=0 all on the same edge.
- Priority: on simultaneous requests at entry or at the WAIT→GRANT decision, VIC wins.
- Invariants:
  - vic_grant and ext_grant are never both 1.
  - grant=1 implies aec=0 and rdy=0.
  - aec=0 implies rdy=0.
- steal_cnt:
  - Increments by 1 on every cyc_stb edge at which the current state is GRANT_VIC or GRANT_EXT.
  - Saturates at all-ones; no wrap.
  - cnt_clr=1 clears it to 0; clear wins over a simultaneous increment.
- cyc_stb=0: no state, output or counter change, except cnt_clr and reset.

Decomposition:
- Shared package c64_bus_pkg:
  - Arbiter state enum (IDLE, WAIT, GRANT_VIC, GRANT_EXT).
  - Constant C64_BA_DELAY=3, reused by the VIC-II model.
- Sub-module sat_counter (width parameter; inc, clr, synchronous reset) for steal_cnt.
- State machine and delay counter stay in c64_bus_arbiter.

Test Plan:
- VIC request with BA_DELAY=3: raise vic_req before strobe 10 → rdy=0 after strobe 10; aec=0 and vic_grant=1 after strobe 13. Drop vic_req before strobe 20 → rdy=1, aec=1, grant=0 after strobe 20; steal_cnt=7 (strobes 14–20).
- Abort: vic_req high at strobe 5 only, low at strobe 6 → rdy=0 after 5, rdy=1 after 6; aec never low; steal_cnt=0.
- Priority and handover: vic_req and ext_req both raised at strobe 2 → vic_grant after strobe 5. Drop vic_req at strobe 8 with ext_req still high → ext_grant=1 after strobe 8, aec stays 0 throughout. Raise vic_req at strobe 9 → no preemption, ext_grant remains 1.
- BA_DELAY=0 instance: ext_req seen at strobe 1 → rdy=0, aec=0, ext_grant=1 after strobe 1.
- Saturation/clear: CNT_W=4, hold grant for 20 strobes → steal_cnt stops at 15. Assert cnt_clr together with cyc_stb during a grant → steal_cnt=0.
- Reset mid-grant: assert reset while in GRANT_VIC → next edge: rdy=1, aec=1, grants=0, steal_cnt=0, regardless of cyc_stb.
